// File: rtl/sopc_nios_processor_oci_dct_pkg.sv
// Shared constants and encodings for the OCI DCT packer.
// The frame layout is {count, buffer}, with count in the top bits.
package sopc_nios_processor_oci_dct_pkg;

  localparam int unsigned CODE_W  = 2;
  localparam int unsigned DEPTH   = 15;
  localparam int unsigned BUF_W   = CODE_W * DEPTH;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FRAME_W = CNT_W + BUF_W;

  localparam int unsigned FRAME_CNT_LSB = BUF_W;
  localparam int unsigned FRAME_CNT_MSB = FRAME_W - 1;

  localparam logic [CNT_W-1:0] CountFull = CNT_W'(DEPTH);

  typedef enum logic [CODE_W-1:0] {
    DctNotTaken  = 2'b00,
    DctTaken     = 2'b01,
    DctException = 2'b10,
    DctReserved  = 2'b11
  } dct_code_e;

endpackage

// File: rtl/sopc_nios_processor_oci_dct_hold.sv
// One-deep valid/ready frame register. The data is held stable while the
// register is occupied and the downstream side is not ready.
module sopc_nios_processor_oci_dct_hold
  import sopc_nios_processor_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               ready,
  output logic               free,
  output logic               valid,
  output logic [FRAME_W-1:0] data
);

  logic               valid_q, valid_d;
  logic [FRAME_W-1:0] data_q, data_d;

  // Free when empty or when the current frame leaves on this edge.
  assign free = ~valid_q | ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/sopc_nios_processor_oci_dct_packer.sv
// Packs 2-bit DCT branch codes into a 30-bit shift buffer and closes full or
// flushed buffers into a one-deep hold register offered downstream.
module sopc_nios_processor_oci_dct_packer
  import sopc_nios_processor_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               trc_on,
  input  logic               dct_valid,
  input  logic [CODE_W-1:0]  dct_code,
  input  logic               flush,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [FRAME_W-1:0] frame_data,
  output logic               overflow,
  input  logic               ovf_clr
);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flush_pending_q, flush_pending_d;
  logic             overflow_q, overflow_d;

  logic accept, full, close, hold_free, load, drop;

  assign accept = trc_on & dct_valid;
  assign full   = (count_q == CountFull);
  assign close  = full | (flush_pending_q & (count_q != '0));
  assign load   = close & hold_free;

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    drop    = 1'b0;
    if (load) begin
      // Packer restarts; a code arriving on the close cycle opens the next frame.
      buf_d   = accept ? {{(BUF_W - CODE_W){1'b0}}, dct_code} : '0;
      count_d = accept ? CNT_W'(1) : '0;
    end else if (accept) begin
      if (full) begin
        drop = 1'b1;
      end else begin
        buf_d   = {buf_q[BUF_W-CODE_W-1:0], dct_code};
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // A flush on an empty packer with no incoming code is a no-op.
  always_comb begin
    if (load) begin
      flush_pending_d = flush & accept;
    end else begin
      flush_pending_d = flush_pending_q | (flush & ((count_q != '0) | accept));
    end
  end

  assign overflow_d = drop | (overflow_q & ~ovf_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q           <= '0;
      count_q         <= '0;
      flush_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      buf_q           <= buf_d;
      count_q         <= count_d;
      flush_pending_q <= flush_pending_d;
      overflow_q      <= overflow_d;
    end
  end

  sopc_nios_processor_oci_dct_hold u_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data ({count_q, buf_q}),
    .ready     (frame_ready),
    .free      (hold_free),
    .valid     (frame_valid),
    .data      (frame_data)
  );

  assign dct_buffer = buf_q;
  assign dct_count  = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sopc_nios_processor_oci_dct_packer.sv
// Directed bench for the OCI DCT packer with hand-computed expectations.
module tb_sopc_nios_processor_oci_dct_packer;
  import sopc_nios_processor_oci_dct_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              trc_on;
  logic              dct_valid;
  logic [1:0]        dct_code;
  logic              flush;
  logic [29:0]       dct_buffer;
  logic [3:0]        dct_count;
  logic              frame_valid;
  logic              frame_ready;
  logic [33:0]       frame_data;
  logic              overflow;
  logic              ovf_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sopc_nios_processor_oci_dct_packer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .trc_on      (trc_on),
    .dct_valid   (dct_valid),
    .dct_code    (dct_code),
    .flush       (flush),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] c);
    trc_on    = 1'b1;
    dct_valid = 1'b1;
    dct_code  = c;
    tick();
    dct_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    trc_on      = 1'b0;
    dct_valid   = 1'b0;
    dct_code    = 2'b00;
    flush       = 1'b0;
    frame_ready = 1'b1;
    ovf_clr     = 1'b0;
    #12;
    check("rst_count", 64'(dct_count), 64'd0);
    check("rst_buffer", 64'(dct_buffer), 64'd0);
    check("rst_fvalid", 64'(frame_valid), 64'd0);
    check("rst_fdata", 64'(frame_data), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: fifteen taken codes close a full frame.
    for (int i = 0; i < 15; i++) push(DctTaken);
    check("t1_count15", 64'(dct_count), 64'd15);
    check("t1_buf", 64'(dct_buffer), 64'h15555555);
    check("t1_notyet", 64'(frame_valid), 64'd0);
    tick();
    check("t1_fvalid", 64'(frame_valid), 64'd1);
    check("t1_fdata", 64'(frame_data), 64'({4'hF, 30'h15555555}));
    check("t1_count0", 64'(dct_count), 64'd0);
    tick();
    check("t1_drained", 64'(frame_valid), 64'd0);

    // 2: partial flush, then flush of an empty packer.
    push(DctException);
    push(DctTaken);
    push(DctNotTaken);
    pulse_flush();
    check("t2_count3", 64'(dct_count), 64'd3);
    tick();
    check("t2_fvalid", 64'(frame_valid), 64'd1);
    check("t2_fdata", 64'(frame_data), 64'({4'h3, 30'h24}));
    check("t2_count0", 64'(dct_count), 64'd0);
    tick();
    pulse_flush();
    tick();
    tick();
    check("t2_noframe", 64'(frame_valid), 64'd0);

    // 4: a code arriving on the close cycle starts the next frame.
    for (int i = 0; i < 15; i++) push(DctReserved);
    push(DctTaken);
    check("t4_fdata", 64'(frame_data), 64'({4'hF, 30'h3FFFFFFF}));
    check("t4_count1", 64'(dct_count), 64'd1);
    check("t4_buf", 64'(dct_buffer), 64'd1);
    tick();
    pulse_flush();
    tick();
    check("t4_tail", 64'(frame_data), 64'({4'h1, 30'h1}));
    tick();
    check("t4_drained", 64'(frame_valid), 64'd0);

    // 3 and 5: backpressure, overflow and sticky clear.
    frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) push(DctTaken);
    for (int i = 0; i < 15; i++) push(DctException);
    check("t3_fvalid", 64'(frame_valid), 64'd1);
    check("t3_first", 64'(frame_data), 64'({4'hF, 30'h15555555}));
    check("t3_count15", 64'(dct_count), 64'd15);
    check("t3_buf2", 64'(dct_buffer), 64'h2AAAAAAA);
    check("t3_noovf", 64'(overflow), 64'd0);
    push(DctReserved);
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_bufkeep", 64'(dct_buffer), 64'h2AAAAAAA);
    check("t3_stable", 64'(frame_data), 64'({4'hF, 30'h15555555}));
    ovf_clr = 1'b1;
    push(DctReserved);
    check("t5_dropwins", 64'(overflow), 64'd1);
    tick();
    ovf_clr = 1'b0;
    check("t5_cleared", 64'(overflow), 64'd0);
    frame_ready = 1'b1;
    tick();
    check("t3_second", 64'(frame_data), 64'({4'hF, 30'h2AAAAAAA}));
    check("t3_fvalid2", 64'(frame_valid), 64'd1);
    check("t3_count0", 64'(dct_count), 64'd0);
    tick();
    check("t3_drained", 64'(frame_valid), 64'd0);

    // 6: asynchronous reset mid-frame.
    frame_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(DctTaken);
    pulse_flush();
    tick();
    check("t6_fdata", 64'(frame_data), 64'({4'h3, 30'h15}));
    for (int i = 0; i < 7; i++) push(DctException);
    check("t6_count7", 64'(dct_count), 64'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_count", 64'(dct_count), 64'd0);
    check("t6_buf", 64'(dct_buffer), 64'd0);
    check("t6_fvalid", 64'(frame_valid), 64'd0);
    check("t6_fdata", 64'(frame_data), 64'd0);
    check("t6_ovf", 64'(overflow), 64'd0);
    #1;
    reset_n     = 1'b1;
    frame_ready = 1'b1;
    tick();
    push(DctTaken);
    push(DctTaken);
    check("t6_resume_cnt", 64'(dct_count), 64'd2);
    check("t6_resume_buf", 64'(dct_buffer), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against the run stalling.
  initial begin
    #100000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1);
  end

endmodule
